tqvp_layer_compositor: RTL and testbench
========================================

# tqvp_layer_compositor

Parametrised successor to the single-select scrolling-background peripheral. It sits on the TinyQV peripheral bus and composites up to 8 external background-layer generators by fixed priority, with colour-key transparency. Per-layer scroll offsets and auto-scroll velocities are double-buffered at frame start. The block drives the VGA PMOD on `uo_out` with syncs delay-matched to layer latency, and raises vblank and config-error interrupts.

## Interface

**Parameters**
- NUM_LAYERS, 4, number of layer channels (1..8); layer 0 has highest priority.
- LAYER_LAT, 2, cycles from layer_x/layer_y to valid layer_rgb (0..4).

**Ports**
- clk  in  1  project clock (64 MHz).
- rst_n  in  1  reset; **asynchronous, active-low**; all state clears immediately on assertion.
- address  in  6  register address.
- data_in  in  32  write data.
- data_write_n  in  2  11 = none; only 10 (32-bit) writes are honoured, 00/01 are ignored.
- data_read_n  in  2  unused (reads have no side effects).
- data_out  out  32  read data, combinational from address.
- data_ready  out  1  constant 1.
- user_interrupt  out  1  (vblank_pend & VB_IE) | (err_pend & ERR_IE), registered.
- pix_x, pix_y  in  11 each  timing-generator coordinates.
- visible, hsync, vsync  in  1 each  timing-generator outputs; positive-polarity syncs.
- layer_x, layer_y  out  NUM_LAYERS*11 each  scrolled coordinates, layer i at [11i+10:11i].
- layer_rgb  in  NUM_LAYERS*6  layer colours {B[1:0],G[1:0],R[1:0]}, layer i at [6i+5:6i].
- uo_out  out  8  {vsync, hsync, B[1:0], G[1:0], R[1:0]}, registered.

## Operation

**Register map** (all registers reset to 0; unmapped addresses read 0, writes ignored)
- 0x00 CTRL
  - [0] EN; [15:8] layer enable mask; [16] VB_IE; [17] ERR_IE.
  - Writing a mask bit ≥ NUM_LAYERS stores 0 for that bit and sets err_pend.
- 0x04 STATUS
  - [0] vblank_pend; [1] err_pend; [31:16] frame_cnt (read-only).
  - Writing 1 to bit 0 or bit 1 clears that pending flag.
- 0x08 BGCOLOR [5:0]; 0x0C KEYCOLOR [5:0].
- 0x10+4i SCROLL_i: [10:0] x offset, [26:16] y offset. Addresses for i ≥ NUM_LAYERS read 0.
- 0x30 VEL: [4i+3:4i] signed x velocity for layer i, in pixels per frame.

**Frame start**
- Frame start is detected as `vsync & ~vsync_q`, where vsync_q is a registered copy of the vsync input.
- At frame start, only while EN = 1:
  - SCROLL_i.x is updated to (x + sext(VEL_i)) mod 2048.
  - The active offsets take the updated x and the current y.
  - The active mask is loaded from the CTRL mask.
  - frame_cnt increments, wrapping at 0xFFFF → 0.
  - vblank_pend is set.
- A CPU write to SCROLL_i in the frame-start cycle wins the register update. The active offsets take the pre-write value plus velocity; the written value applies from the next frame.
- When a pending flag is set and cleared in the same cycle, set wins.
- While EN = 0, the active offsets, frame_cnt and auto-scroll are frozen.

**Coordinates**
- layer_x_i = (pix_x + active_x_i) mod 2048, combinational.
- layer_y_i = (pix_y + active_y_i) mod 2048, combinational.

**Compositing**
- visible, hsync and vsync are delayed LAYER_LAT cycles to align with layer_rgb.
- Layer i is opaque when its active mask bit is 1 and layer_rgb_i ≠ KEYCOLOR.
- Pixel colour = lowest-index opaque layer; BGCOLOR if no layer is opaque; 0 if delayed visible = 0.
- uo_out is registered from the aligned syncs and the pixel colour.
- EN = 0 forces uo_out to 0.

## Timing

- Latency from hsync/vsync/visible input to uo_out is LAYER_LAT+1 cycles.
- A register write is visible on data_out the cycle after the write.
- Mask and offset changes take effect only at the next frame start, never mid-frame.
- user_interrupt asserts 1 cycle after its pending flag sets.
- user_interrupt deasserts 1 cycle after the W1C write, or after the enable bit is cleared.
- Reset values:
  - uo_out = 0, user_interrupt = 0, frame_cnt = 0.
  - All delay-line stages = 0.
  - layer_x = pix_x and layer_y = pix_y (offsets 0).
- Asserting reset mid-frame clears everything asynchronously.
- After reset deasserts, the first vsync rise with EN = 1 is treated as frame start.

## Test plan

- **Reset and readback.** Assert reset, then write CTRL = 0x0000_0301 and SCROLL_1 = 0x0005_0010.
  - Read back CTRL = 0x301 and SCROLL_1 = 0x50010.
  - uo_out = 0 until the first frame start.
- **Priority and key.** NUM_LAYERS = 4, mask 0x0F, KEYCOLOR = 0x00, BGCOLOR = 0x15, layer_rgb = {L3 = 0x3F, L2 = 0x0C, L1 = 0x00, L0 = 0x00}, visible = 1.
  - uo_out[5:0] = 0x0C exactly LAYER_LAT+1 cycles later.
  - With all layers at 0x00, uo_out[5:0] = 0x15.
- **Auto-scroll wrap.** SCROLL_0.x = 2046, VEL_0 = +3.
  - After 1 frame start, SCROLL_0 reads x = 1 and layer_x_0 at pix_x = 0 is 1.
  - With VEL_0 = −2 from x = 1, the next frame gives x = 2047.
- **Double-buffering.** Write SCROLL_0 and mask mid-frame.
  - layer_x_0 and uo_out are unchanged until the next vsync rise.
  - A write landing in the frame-start cycle is applied one frame later.
- **Interrupts.**
  - With VB_IE = 1, vsync rise sets vblank_pend and user_interrupt = 1; STATUS write 0x1 clears it.
  - A CTRL mask bit 7 write with NUM_LAYERS = 4 sets err_pend, and CTRL reads mask bit 7 = 0.
  - Set and clear in the same cycle leaves the flag = 1.
- **Frame counter.** With EN = 1, 3 vsync pulses give frame_cnt = 3.
  - With EN = 0, further pulses leave frame_cnt = 3.
  - Reset asserted mid-frame returns frame_cnt to 0 immediately.

Source files
------------

// File: rtl/tqvp_layer_compositor_if.sv
// TinyQV peripheral bus bundle for the layer compositor: register address/data plus read-back.
interface tqvp_layer_compositor_if;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;

    modport master (
        output address, data_in, data_write_n, data_read_n,
        input  data_out, data_ready
    );

    modport slave (
        input  address, data_in, data_write_n, data_read_n,
        output data_out, data_ready
    );
endinterface

// File: rtl/tqvp_layer_compositor.sv
// Fixed-priority colour-keyed compositor of up to 8 background layers, with frame-start
// double-buffered scroll offsets, auto-scroll, sync delay matching and interrupts.
module tqvp_layer_compositor #(
    parameter int unsigned NUM_LAYERS = 4,
    parameter int unsigned LAYER_LAT  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    tqvp_layer_compositor_if.slave     bus,
    output logic                       user_interrupt,
    input  logic [10:0]                pix_x,
    input  logic [10:0]                pix_y,
    input  logic                       visible,
    input  logic                       hsync,
    input  logic                       vsync,
    output logic [NUM_LAYERS*11-1:0]   layer_x,
    output logic [NUM_LAYERS*11-1:0]   layer_y,
    input  logic [NUM_LAYERS*6-1:0]    layer_rgb,
    output logic [7:0]                 uo_out
);
    localparam int unsigned NL = NUM_LAYERS;
    localparam int unsigned DL = (LAYER_LAT == 0) ? 1 : LAYER_LAT;

    logic              en_q, vb_ie_q, err_ie_q;
    logic [NL-1:0]     mask_q, act_mask_q;
    logic              vblank_pend_q, err_pend_q;
    logic [15:0]       frame_cnt_q;
    logic [5:0]        bg_q, key_q;
    logic [31:0]       vel_q;
    logic [10:0]       scroll_x_q [NL];
    logic [10:0]       scroll_y_q [NL];
    logic [10:0]       act_x_q    [NL];
    logic [10:0]       act_y_q    [NL];
    logic              vsync_q;

    logic              wr, wr_ctrl, wr_status, frame_start;
    logic              set_err, clr_vb, clr_err;
    logic [NL-1:0]     wr_scroll;
    logic [10:0]       next_x [NL];

    logic              unused;
    assign unused = ^bus.data_read_n;

    assign bus.data_ready = 1'b1;

    // Bus decode; only full 32-bit writes are honoured
    always_comb begin
        wr        = (bus.data_write_n == 2'b10);
        wr_ctrl   = wr && (bus.address == 6'h00);
        wr_status = wr && (bus.address == 6'h04);
        set_err   = wr_ctrl && (|(bus.data_in[15:8] >> NL));
        clr_vb    = wr_status && bus.data_in[0];
        clr_err   = wr_status && bus.data_in[1];
        frame_start = vsync && !vsync_q && en_q;
        wr_scroll = '0;
        for (int i = 0; i < int'(NL); i++) begin
            wr_scroll[i] = wr && (bus.address == 6'(16 + 4 * i));
            next_x[i]    = scroll_x_q[i] + {{7{vel_q[4*i+3]}}, vel_q[4*i +: 4]};
        end
    end

    // Register file, frame-start shadow load and interrupt flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q           <= 1'b0;
            vb_ie_q        <= 1'b0;
            err_ie_q       <= 1'b0;
            mask_q         <= '0;
            act_mask_q     <= '0;
            vblank_pend_q  <= 1'b0;
            err_pend_q     <= 1'b0;
            frame_cnt_q    <= '0;
            bg_q           <= '0;
            key_q          <= '0;
            vel_q          <= '0;
            vsync_q        <= 1'b0;
            user_interrupt <= 1'b0;
            for (int i = 0; i < int'(NL); i++) begin
                scroll_x_q[i] <= '0;
                scroll_y_q[i] <= '0;
                act_x_q[i]    <= '0;
                act_y_q[i]    <= '0;
            end
        end else begin
            vsync_q <= vsync;
            if (wr_ctrl) begin
                en_q     <= bus.data_in[0];
                mask_q   <= bus.data_in[8 +: NL];
                vb_ie_q  <= bus.data_in[16];
                err_ie_q <= bus.data_in[17];
            end
            if (wr && bus.address == 6'h08) bg_q  <= bus.data_in[5:0];
            if (wr && bus.address == 6'h0C) key_q <= bus.data_in[5:0];
            if (wr && bus.address == 6'h30) vel_q <= bus.data_in;
            // Set beats clear when both land in the same cycle
            vblank_pend_q <= (vblank_pend_q && !clr_vb) || frame_start;
            err_pend_q    <= (err_pend_q && !clr_err) || set_err;
            if (frame_start) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
                act_mask_q  <= mask_q;
            end
            // A CPU write in the frame-start cycle wins the register; active takes pre-write value
            for (int i = 0; i < int'(NL); i++) begin
                if (wr_scroll[i]) begin
                    scroll_x_q[i] <= bus.data_in[10:0];
                    scroll_y_q[i] <= bus.data_in[26:16];
                end else if (frame_start) begin
                    scroll_x_q[i] <= next_x[i];
                end
                if (frame_start) begin
                    act_x_q[i] <= next_x[i];
                    act_y_q[i] <= scroll_y_q[i];
                end
            end
            user_interrupt <= (vblank_pend_q && vb_ie_q) || (err_pend_q && err_ie_q);
        end
    end

    // Register read-back
    always_comb begin
        bus.data_out = '0;
        case (bus.address)
            6'h00:   bus.data_out = {14'd0, err_ie_q, vb_ie_q, 8'(mask_q), 7'd0, en_q};
            6'h04:   bus.data_out = {frame_cnt_q, 14'd0, err_pend_q, vblank_pend_q};
            6'h08:   bus.data_out = {26'd0, bg_q};
            6'h0C:   bus.data_out = {26'd0, key_q};
            6'h30:   bus.data_out = vel_q;
            default: bus.data_out = '0;
        endcase
        for (int i = 0; i < int'(NL); i++) begin
            if (bus.address == 6'(16 + 4 * i))
                bus.data_out = {5'd0, scroll_y_q[i], 5'd0, scroll_x_q[i]};
        end
    end

    // Scrolled coordinates handed to the layer generators
    always_comb begin
        layer_x = '0;
        layer_y = '0;
        for (int i = 0; i < int'(NL); i++) begin
            layer_x[11*i +: 11] = pix_x + act_x_q[i];
            layer_y[11*i +: 11] = pix_y + act_y_q[i];
        end
    end

    logic [2:0] sync_d [DL];
    logic [2:0] aligned;
    logic [5:0] pix_c;

    // visible/hsync/vsync delay line matching layer latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(DL); k++) sync_d[k] <= '0;
        end else begin
            sync_d[0] <= {visible, hsync, vsync};
            for (int k = 1; k < int'(DL); k++) sync_d[k] <= sync_d[k-1];
        end
    end

    assign aligned = (LAYER_LAT == 0) ? {visible, hsync, vsync} : sync_d[DL-1];

    // Lowest-index opaque layer wins; scan from lowest priority upward
    always_comb begin
        pix_c = bg_q;
        for (int i = int'(NL) - 1; i >= 0; i--) begin
            if (act_mask_q[i] && (layer_rgb[6*i +: 6] != key_q))
                pix_c = layer_rgb[6*i +: 6];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            uo_out <= '0;
        else if (!en_q)
            uo_out <= '0;
        else
            uo_out <= {aligned[0], aligned[1], aligned[2] ? pix_c : 6'd0};
    end
endmodule

// File: tb/tb_tqvp_layer_compositor.sv
// Scoreboard bench for tqvp_layer_compositor: register map, compositing, scroll and interrupts.
module tb_tqvp_layer_compositor;
    localparam int unsigned NL  = 4;
    localparam int unsigned LAT = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [10:0]       pix_x, pix_y;
    logic              visible, hsync, vsync;
    logic [NL*11-1:0]  layer_x, layer_y;
    logic [NL*6-1:0]   layer_rgb;
    logic [7:0]        uo_out;
    logic              user_interrupt;

    tqvp_layer_compositor_if bus_if ();

    tqvp_layer_compositor #(.NUM_LAYERS(NL), .LAYER_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus_if), .user_interrupt(user_interrupt),
        .pix_x(pix_x), .pix_y(pix_y), .visible(visible), .hsync(hsync), .vsync(vsync),
        .layer_x(layer_x), .layer_y(layer_y), .layer_rgb(layer_rgb), .uo_out(uo_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct { int due; logic [7:0] val; } exp_t;
    exp_t sb[$];

    logic          b_en;
    logic [NL-1:0] b_mask, b_mask_ctrl;
    logic [5:0]    b_key, b_bg;
    logic [5:0]    b_rgb [NL];
    logic [31:0]   rd;

    function automatic logic [5:0] model_colour();
        for (int i = 0; i < int'(NL); i++)
            if (b_mask[i] && b_rgb[i] != b_key) return b_rgb[i];
        return b_bg;
    endfunction

    task automatic apply_rgb();
        for (int i = 0; i < int'(NL); i++) layer_rgb[6*i +: 6] = b_rgb[i];
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_if.address = a; bus_if.data_in = d; bus_if.data_write_n = 2'b10;
        @(negedge clk);
        bus_if.data_write_n = 2'b11;
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
        bus_if.address = a;
        #1 d = bus_if.data_out;
    endtask

    task automatic frame_pulse();
        @(negedge clk); vsync = 1'b1;
        @(negedge clk); vsync = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        if (b_en) b_mask = b_mask_ctrl;
    endtask

    // vsync rise and a register write land on the same clock edge
    task automatic frame_with_write(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        vsync = 1'b1; bus_if.address = a; bus_if.data_in = d; bus_if.data_write_n = 2'b10;
        @(negedge clk);
        vsync = 1'b0; bus_if.data_write_n = 2'b11;
        repeat (LAT + 2) @(negedge clk);
        if (b_en) b_mask = b_mask_ctrl;
    endtask

    // Random visible/hsync stream; expectations queued at drive time, popped LAT+1 clocks later
    task automatic run_stream(input string name, input int n);
        int cyc = 0;
        exp_t e;
        for (int c = 0; c < n + int'(LAT) + 1; c++) begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                checks++;
                if (uo_out !== e.val) begin
                    errors++;
                    $display("FAIL stream_%s cyc %0d: uo_out=%02h expected %02h", name, cyc, uo_out, e.val);
                end
            end
            if (c < n) begin
                visible = 1'($urandom_range(0, 1));
                hsync   = 1'($urandom_range(0, 1));
                e.due = cyc + int'(LAT) + 1;
                e.val = b_en ? {1'b0, hsync, visible ? model_colour() : 6'd0} : 8'd0;
                sb.push_back(e);
            end
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        visible = 1'b0; hsync = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL stream_%s_drain: %0d entries left, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pix_x = 11'd123; pix_y = 11'd45;
        repeat (3) @(negedge clk);
        checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_uo_out: got %02h expected 00", uo_out); end
        checks++; if (user_interrupt !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", user_interrupt); end
        checks++; if (bus_if.data_ready !== 1'b1) begin errors++; $display("FAIL data_ready: got %b expected 1", bus_if.data_ready); end
        bus_read(6'h04, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_status: got %08h expected 0", rd); end
        checks++; if (layer_x[32:22] !== 11'd123) begin errors++; $display("FAIL reset_layer_x2: got %0d expected 123", layer_x[32:22]); end
        checks++; if (layer_y[43:33] !== 11'd45) begin errors++; $display("FAIL reset_layer_y3: got %0d expected 45", layer_y[43:33]); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_readback();
        bus_write(6'h00, 32'h0000_0301); b_en = 1'b1; b_mask_ctrl = 4'b0011;
        bus_write(6'h14, 32'h0005_0010);
        bus_read(6'h00, rd);
        checks++; if (rd !== 32'h301) begin errors++; $display("FAIL readback_ctrl: got %08h expected 00000301", rd); end
        bus_read(6'h14, rd);
        checks++; if (rd !== 32'h50010) begin errors++; $display("FAIL readback_scroll1: got %08h expected 00050010", rd); end
        @(negedge clk);
        bus_if.address = 6'h08; bus_if.data_in = 32'h3F; bus_if.data_write_n = 2'b01;
        @(negedge clk); bus_if.data_write_n = 2'b11;
        bus_read(6'h08, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL halfword_write_ignored: got %08h expected 0", rd); end
        bus_write(6'h24, 32'h0123_0456);
        bus_read(6'h24, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL scroll5_unmapped: got %08h expected 0", rd); end
        checks++; if (layer_x[21:11] !== 11'd123) begin errors++; $display("FAIL scroll1_not_active: got %0d expected 123", layer_x[21:11]); end
        visible = 1'b1;
        repeat (LAT + 3) @(negedge clk);
        checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL pre_frame_uo_out: got %02h expected 00", uo_out); end
        visible = 1'b0;
    endtask

    task automatic test_priority();
        bus_write(6'h0C, 32'h00); b_key = 6'h00;
        bus_write(6'h08, 32'h15); b_bg = 6'h15;
        bus_write(6'h00, 32'h0F01); b_mask_ctrl = 4'hF;
        frame_pulse();
        b_rgb[0] = 6'h00; b_rgb[1] = 6'h00; b_rgb[2] = 6'h0C; b_rgb[3] = 6'h3F;
        apply_rgb();
        run_stream("priority", 12);
        for (int i = 0; i < int'(NL); i++) b_rgb[i] = 6'h00;
        apply_rgb();
        run_stream("all_keyed", 8);
        for (int r = 0; r < 3; r++) begin
            b_key = 6'($urandom_range(0, 63));
            bus_write(6'h0C, {26'd0, b_key});
            for (int i = 0; i < int'(NL); i++)
                b_rgb[i] = ($urandom_range(0, 1) == 1) ? b_key : 6'($urandom_range(0, 63));
            apply_rgb();
            run_stream("random", 8);
        end
        bus_write(6'h0C, 32'h00); b_key = 6'h00;
    endtask

    task automatic test_scroll_wrap();
        bus_write(6'h10, 32'd2046);
        bus_write(6'h30, 32'h3);
        frame_pulse();
        pix_x = 11'd0; pix_y = 11'd0;
        bus_read(6'h10, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL wrap_plus_scroll0: got %08h expected 00000001", rd); end
        checks++; if (layer_x[10:0] !== 11'd1) begin errors++; $display("FAIL wrap_plus_layer_x0: got %0d expected 1", layer_x[10:0]); end
        checks++; if (layer_x[21:11] !== 11'd16) begin errors++; $display("FAIL scroll1_layer_x: got %0d expected 16", layer_x[21:11]); end
        checks++; if (layer_y[21:11] !== 11'd5) begin errors++; $display("FAIL scroll1_layer_y: got %0d expected 5", layer_y[21:11]); end
        bus_write(6'h30, 32'hE);
        frame_pulse();
        bus_read(6'h10, rd);
        checks++; if (rd !== 32'h7FF) begin errors++; $display("FAIL wrap_minus_scroll0: got %08h expected 000007ff", rd); end
        checks++; if (layer_x[10:0] !== 11'd2047) begin errors++; $display("FAIL wrap_minus_layer_x0: got %0d expected 2047", layer_x[10:0]); end
    endtask

    task automatic test_double_buffer();
        b_rgb[0] = 6'h2A; b_rgb[1] = 6'h00; b_rgb[2] = 6'h0C; b_rgb[3] = 6'h3F;
        apply_rgb();
        bus_write(6'h30, 32'h1);
        bus_write(6'h10, 32'd100);
        checks++; if (layer_x[10:0] !== 11'd2047) begin errors++; $display("FAIL midframe_layer_x0: got %0d expected 2047", layer_x[10:0]); end
        run_stream("old_mask", 8);
        bus_write(6'h00, 32'h0E01); b_mask_ctrl = 4'hE;
        run_stream("mask_pending", 8);
        checks++; if (layer_x[10:0] !== 11'd2047) begin errors++; $display("FAIL midframe_layer_x0_b: got %0d expected 2047", layer_x[10:0]); end
        frame_pulse();
        checks++; if (layer_x[10:0] !== 11'd101) begin errors++; $display("FAIL newframe_layer_x0: got %0d expected 101", layer_x[10:0]); end
        run_stream("new_mask", 8);
        frame_with_write(6'h10, 32'd500);
        checks++; if (layer_x[10:0] !== 11'd102) begin errors++; $display("FAIL fs_write_active: got %0d expected 102", layer_x[10:0]); end
        bus_read(6'h10, rd);
        checks++; if (rd !== 32'd500) begin errors++; $display("FAIL fs_write_reg: got %0d expected 500", rd); end
        frame_pulse();
        checks++; if (layer_x[10:0] !== 11'd501) begin errors++; $display("FAIL fs_write_next_active: got %0d expected 501", layer_x[10:0]); end
        bus_read(6'h10, rd);
        checks++; if (rd !== 32'd501) begin errors++; $display("FAIL fs_write_next_reg: got %0d expected 501", rd); end
    endtask

    task automatic test_interrupts();
        bus_write(6'h04, 32'h3);
        bus_read(6'h04, rd);
        checks++; if (rd[1:0] !== 2'b00) begin errors++; $display("FAIL w1c_both: got %b expected 00", rd[1:0]); end
        bus_write(6'h00, 32'h0001_0E01);
        checks++; if (user_interrupt !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b expected 0", user_interrupt); end
        @(negedge clk); vsync = 1'b1;
        @(negedge clk); vsync = 1'b0;
        bus_read(6'h04, rd);
        checks++; if (rd[0] !== 1'b1) begin errors++; $display("FAIL vblank_set: got %b expected 1", rd[0]); end
        checks++; if (user_interrupt !== 1'b0) begin errors++; $display("FAIL irq_early: got %b expected 0", user_interrupt); end
        @(negedge clk);
        checks++; if (user_interrupt !== 1'b1) begin errors++; $display("FAIL irq_vblank: got %b expected 1", user_interrupt); end
        bus_write(6'h04, 32'h1);
        bus_read(6'h04, rd);
        checks++; if (rd[0] !== 1'b0) begin errors++; $display("FAIL vblank_clear: got %b expected 0", rd[0]); end
        @(negedge clk);
        checks++; if (user_interrupt !== 1'b0) begin errors++; $display("FAIL irq_vblank_clear: got %b expected 0", user_interrupt); end
        bus_write(6'h00, 32'h0002_8F01); b_mask_ctrl = 4'hF;
        bus_read(6'h00, rd);
        checks++; if (rd !== 32'h0002_0F01) begin errors++; $display("FAIL ctrl_mask7: got %08h expected 00020f01", rd); end
        bus_read(6'h04, rd);
        checks++; if (rd[1] !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected 1", rd[1]); end
        @(negedge clk);
        checks++; if (user_interrupt !== 1'b1) begin errors++; $display("FAIL irq_err: got %b expected 1", user_interrupt); end
        bus_write(6'h04, 32'h2);
        @(negedge clk);
        checks++; if (user_interrupt !== 1'b0) begin errors++; $display("FAIL irq_err_clear: got %b expected 0", user_interrupt); end
        frame_with_write(6'h04, 32'h1);
        bus_read(6'h04, rd);
        checks++; if (rd[1:0] !== 2'b01) begin errors++; $display("FAIL set_beats_clear: got %b expected 01", rd[1:0]); end
        bus_write(6'h00, 32'h0001_0F01);
        @(negedge clk);
        checks++; if (user_interrupt !== 1'b1) begin errors++; $display("FAIL irq_ie_on: got %b expected 1", user_interrupt); end
        bus_write(6'h00, 32'h0000_0F01);
        @(negedge clk);
        checks++; if (user_interrupt !== 1'b0) begin errors++; $display("FAIL irq_ie_off: got %b expected 0", user_interrupt); end
    endtask

    task automatic test_frame_cnt();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        b_en = 1'b0; b_mask = '0; b_mask_ctrl = '0; b_bg = 6'h00;
        bus_write(6'h00, 32'h1); b_en = 1'b1;
        repeat (3) frame_pulse();
        bus_read(6'h04, rd);
        checks++; if (rd[31:16] !== 16'd3) begin errors++; $display("FAIL frame_cnt_3: got %0d expected 3", rd[31:16]); end
        bus_write(6'h08, 32'h15); b_bg = 6'h15;
        bus_write(6'h00, 32'h0); b_en = 1'b0;
        repeat (2) frame_pulse();
        bus_read(6'h04, rd);
        checks++; if (rd[31:16] !== 16'd3) begin errors++; $display("FAIL frame_cnt_frozen: got %0d expected 3", rd[31:16]); end
        run_stream("disabled", 6);
        bus_write(6'h00, 32'h1); b_en = 1'b1;
        visible = 1'b1;
        repeat (LAT + 2) @(negedge clk);
        checks++; if (uo_out !== 8'h15) begin errors++; $display("FAIL bgcolor_out: got %02h expected 15", uo_out); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (uo_out !== 8'h00) begin errors++; $display("FAIL async_reset_uo_out: got %02h expected 00", uo_out); end
        bus_read(6'h04, rd);
        checks++; if (rd[31:16] !== 16'd0) begin errors++; $display("FAIL async_reset_frame_cnt: got %0d expected 0", rd[31:16]); end
        visible = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; visible = 1'b0; hsync = 1'b0; vsync = 1'b0;
        pix_x = '0; pix_y = '0; layer_rgb = '0;
        bus_if.address = '0; bus_if.data_in = '0;
        bus_if.data_write_n = 2'b11; bus_if.data_read_n = 2'b11;
        b_en = 1'b0; b_mask = '0; b_mask_ctrl = '0; b_key = '0; b_bg = '0;
        for (int i = 0; i < int'(NL); i++) b_rgb[i] = '0;
        test_reset();
        test_readback();
        test_priority();
        test_scroll_wrap();
        test_double_buffer();
        test_interrupts();
        test_frame_cnt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
